reg_file_sb: RTL and testbench

//  Parametrised multi-port register file with per-register scoreboard for the MIPS datapath.

---
 rtl/reg_file_sb_if.sv | 29 ++
 rtl/reg_file_sb.sv | 92 +++++++++
 tb/tb_reg_file_sb.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: write port, reserve port and the two read ports.
// The master modport drives addresses/enables; the slave modport is the register file.
interface reg_file_sb_if #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5
);
   logic              i_wen;
   logic [ADDR_W-1:0] i_waddr;
   logic [WIDTH-1:0]  i_wdata;
   logic [ADDR_W-1:0] i_raddr1;
   logic [WIDTH-1:0]  o_rdata1;
   logic              o_busy1;
   logic [ADDR_W-1:0] i_raddr2;
   logic [WIDTH-1:0]  o_rdata2;
   logic              o_busy2;
   logic              i_rsv_en;
   logic [ADDR_W-1:0] i_rsv_addr;
   logic              o_rsv_err;

   modport master (
      output i_wen, i_waddr, i_wdata, i_raddr1, i_raddr2, i_rsv_en, i_rsv_addr,
      input  o_rdata1, o_busy1, o_rdata2, o_busy2, o_rsv_err
   );

   modport slave (
      input  i_wen, i_waddr, i_wdata, i_raddr1, i_raddr2, i_rsv_en, i_rsv_addr,
      output o_rdata1, o_busy1, o_rdata2, o_busy2, o_rsv_err
   );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with per-entry busy scoreboard, two combinational reads, one write port.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module reg_file_sb #(
   parameter int WIDTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input logic          clk,
   input logic          rst_n,
   reg_file_sb_if.slave bus
);
   localparam int NREG = 1 << ADDR_W;

   logic [WIDTH-1:0]  r_mem [NREG];
   logic [NREG-1:0]   r_busy;
   logic              r_rsvErr;

   logic              w_wrValid;
   logic              w_rsvValid;
   logic [NREG-1:0]   w_wrHit;
   logic [NREG-1:0]   w_rsvHit;
   logic              w_rsvErrNext;
   logic [ADDR_W-1:0] w_raddr [2];
   logic [WIDTH-1:0]  w_rdata [2];
   logic              w_busy  [2];

   // Entry 0 is hardwired when ZERO_REG is set: writes and reserves to it are dropped.
   assign w_wrValid  = bus.i_wen    && !((ZERO_REG != 0) && (bus.i_waddr    == '0));
   assign w_rsvValid = bus.i_rsv_en && !((ZERO_REG != 0) && (bus.i_rsv_addr == '0));

   always_comb begin
      w_wrHit  = '0;
      w_rsvHit = '0;
      for (int i = 0; i < NREG; i++) begin
         w_wrHit[i]  = w_wrValid  && (bus.i_waddr    == ADDR_W'(i));
         w_rsvHit[i] = w_rsvValid && (bus.i_rsv_addr == ADDR_W'(i));
      end
   end

   // A writeback landing on the same entry this edge retires the old reservation, so no error.
   assign w_rsvErrNext = w_rsvValid && r_busy[bus.i_rsv_addr]
                         && !(bus.i_wen && (bus.i_waddr == bus.i_rsv_addr));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            r_mem[i] <= '0;
         end
         r_busy   <= '0;
         r_rsvErr <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (w_wrHit[i]) begin
               r_mem[i] <= bus.i_wdata;
            end
            if (w_rsvHit[i]) begin
               r_busy[i] <= 1'b1;
            end else if (w_wrHit[i]) begin
               r_busy[i] <= 1'b0;
            end
         end
         r_rsvErr <= w_rsvErrNext;
      end
   end

   assign w_raddr[0] = bus.i_raddr1;
   assign w_raddr[1] = bus.i_raddr2;

   // Outputs are forced to zero while reset is held, even if a forwarded write is pending.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         w_rdata[p] = r_mem[w_raddr[p]];
         w_busy[p]  = r_busy[w_raddr[p]];
`ifdef REGFILE_BYPASS_EN
         if (w_wrValid && (bus.i_waddr == w_raddr[p])) begin
            w_rdata[p] = bus.i_wdata;
            w_busy[p]  = bus.i_rsv_en && (bus.i_rsv_addr == bus.i_waddr);
         end
`endif
         if (((ZERO_REG != 0) && (w_raddr[p] == '0)) || !rst_n) begin
            w_rdata[p] = '0;
            w_busy[p]  = 1'b0;
         end
      end
   end

   assign bus.o_rdata1  = w_rdata[0];
   assign bus.o_busy1   = w_busy[0];
   assign bus.o_rdata2  = w_rdata[1];
   assign bus.o_busy2   = w_busy[1];
   assign bus.o_rsv_err = r_rsvErr;
endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: directed vectors push expectations, a monitor compares them.
// Expectations for same-cycle reads depend on whether REGFILE_BYPASS_EN is defined.
module tb_reg_file_sb;
   localparam int WIDTH  = 32;
   localparam int ADDR_W = 5;

   localparam int SEL_RDATA1 = 0;
   localparam int SEL_BUSY1  = 1;
   localparam int SEL_RDATA2 = 2;
   localparam int SEL_BUSY2  = 3;
   localparam int SEL_RSVERR = 4;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] value;
   } expT;

   logic clk;
   logic rst_n;
   int   checkCount;
   int   failCount;
   expT  sbQ[$];
   event sampleEv;

   reg_file_sb_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) rfIf ();

   reg_file_sb #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (rfIf.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Monitor: every sample point drains the queued expectations against the live outputs.
   initial begin
      forever begin
         @(sampleEv);
         while (sbQ.size() > 0) begin
            expT         e;
            logic [31:0] act;
            e = sbQ.pop_front();
            case (e.sel)
               SEL_RDATA1: act = rfIf.o_rdata1;
               SEL_BUSY1:  act = {31'b0, rfIf.o_busy1};
               SEL_RDATA2: act = rfIf.o_rdata2;
               SEL_BUSY2:  act = {31'b0, rfIf.o_busy2};
               default:    act = {31'b0, rfIf.o_rsv_err};
            endcase
            checkCount++;
            if (act !== e.value) begin
               failCount++;
               $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", e.name, act, e.value);
            end
         end
      end
   end

   task automatic applyStimulus(input logic wen, input logic [ADDR_W-1:0] waddr,
                                input logic [31:0] wdata, input logic rsvEn,
                                input logic [ADDR_W-1:0] rsvAddr,
                                input logic [ADDR_W-1:0] raddr1, input logic [ADDR_W-1:0] raddr2);
      rfIf.i_wen      = wen;
      rfIf.i_waddr    = waddr;
      rfIf.i_wdata    = wdata;
      rfIf.i_rsv_en   = rsvEn;
      rfIf.i_rsv_addr = rsvAddr;
      rfIf.i_raddr1   = raddr1;
      rfIf.i_raddr2   = raddr2;
   endtask

   task automatic checkOutput(input string name, input int sel, input logic [31:0] value);
      expT e;
      e.name  = name;
      e.sel   = sel;
      e.value = value;
      sbQ.push_back(e);
   endtask

   task automatic sampleNow();
      #1;
      -> sampleEv;
      #1;
   endtask

   task automatic idle(input logic [ADDR_W-1:0] raddr1, input logic [ADDR_W-1:0] raddr2);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, raddr1, raddr2);
   endtask

   initial begin
      checkCount = 0;
      failCount  = 0;
      rst_n      = 1'b0;
      idle(5'd5, 5'd5);
      sampleNow();
      checkOutput("reset_rdata1", SEL_RDATA1, 32'h0);
      checkOutput("reset_busy1",  SEL_BUSY1,  32'h0);
      checkOutput("reset_rsverr", SEL_RSVERR, 32'h0);
      sampleNow();

      @(negedge clk);
      rst_n = 1'b1;

      // Async reset: load entry 5, then drop reset between edges.
      @(negedge clk);
      applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd6);
      @(negedge clk);
      idle(5'd5, 5'd6);
      checkOutput("wr5_rdata1", SEL_RDATA1, 32'hDEADBEEF);
      sampleNow();
      applyStimulus(1'b1, 5'd6, 32'h00000066, 1'b1, 5'd6, 5'd5, 5'd6);
      rst_n = 1'b0;
      checkOutput("rstmid_rdata1", SEL_RDATA1, 32'h0);
      checkOutput("rstmid_busy1",  SEL_BUSY1,  32'h0);
      checkOutput("rstmid_rdata2", SEL_RDATA2, 32'h0);
      checkOutput("rstmid_busy2",  SEL_BUSY2,  32'h0);
      sampleNow();
      @(negedge clk);
      idle(5'd5, 5'd6);
      rst_n = 1'b1;
      checkOutput("postrst_rdata2", SEL_RDATA2, 32'h0);
      sampleNow();

      // Entry 0 hardwired.
      @(negedge clk);
      applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
      checkOutput("zero_same_rdata1", SEL_RDATA1, 32'h0);
      checkOutput("zero_same_busy1",  SEL_BUSY1,  32'h0);
      sampleNow();
      @(negedge clk);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
      checkOutput("zero_rdata1", SEL_RDATA1, 32'h0);
      checkOutput("zero_busy1",  SEL_BUSY1,  32'h0);
      checkOutput("zero_rsverr", SEL_RSVERR, 32'h0);
      sampleNow();
      @(negedge clk);
      idle(5'd0, 5'd0);
      checkOutput("zero_rsverr2", SEL_RSVERR, 32'h0);
      sampleNow();

      // Reserve 7, then write it back.
      @(negedge clk);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd5);
      checkOutput("rsv7_pre_busy1", SEL_BUSY1, 32'h0);
      sampleNow();
      @(negedge clk);
      idle(5'd7, 5'd5);
      checkOutput("rsv7_busy1",  SEL_BUSY1,  32'h1);
      checkOutput("rsv7_rsverr", SEL_RSVERR, 32'h0);
      sampleNow();
      applyStimulus(1'b1, 5'd7, 32'h00001234, 1'b0, 5'd0, 5'd7, 5'd5);
      @(negedge clk);
      idle(5'd7, 5'd5);
      checkOutput("wb7_busy1",  SEL_BUSY1,  32'h0);
      checkOutput("wb7_rdata1", SEL_RDATA1, 32'h00001234);
      sampleNow();

      // Same-edge write and reserve of 9.
      @(negedge clk);
      applyStimulus(1'b1, 5'd9, 32'h000000A5, 1'b1, 5'd9, 5'd9, 5'd9);
`ifdef REGFILE_BYPASS_EN
      checkOutput("wr9_same_rdata2", SEL_RDATA2, 32'h000000A5);
      checkOutput("wr9_same_busy2",  SEL_BUSY2,  32'h1);
`else
      checkOutput("wr9_same_rdata2", SEL_RDATA2, 32'h0);
      checkOutput("wr9_same_busy2",  SEL_BUSY2,  32'h0);
`endif
      sampleNow();
      @(negedge clk);
      idle(5'd9, 5'd9);
      checkOutput("wr9_rdata2", SEL_RDATA2, 32'h000000A5);
      checkOutput("wr9_busy2",  SEL_BUSY2,  32'h1);
      checkOutput("wr9_rdata1", SEL_RDATA1, 32'h000000A5);
      checkOutput("wr9_busy1",  SEL_BUSY1,  32'h1);
      checkOutput("wr9_rsverr", SEL_RSVERR, 32'h0);
      sampleNow();

      // Double reserve of 3.
      @(negedge clk);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd7);
      @(negedge clk);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd7);
      checkOutput("dbl3_first_rsverr", SEL_RSVERR, 32'h0);
      sampleNow();
      @(negedge clk);
      idle(5'd3, 5'd7);
      checkOutput("dbl3_rsverr", SEL_RSVERR, 32'h1);
      checkOutput("dbl3_busy1",  SEL_BUSY1,  32'h1);
      checkOutput("dbl3_rdata2", SEL_RDATA2, 32'h00001234);
      sampleNow();
      @(negedge clk);
      checkOutput("dbl3_rsverr_drop", SEL_RSVERR, 32'h0);
      sampleNow();

      // Re-reserve of busy 9 with its writeback on the same edge: no error.
      @(negedge clk);
      applyStimulus(1'b1, 5'd9, 32'h000000B6, 1'b1, 5'd9, 5'd3, 5'd9);
      @(negedge clk);
      idle(5'd3, 5'd9);
      checkOutput("rsvwb9_rsverr", SEL_RSVERR, 32'h0);
      checkOutput("rsvwb9_rdata2", SEL_RDATA2, 32'h000000B6);
      checkOutput("rsvwb9_busy2",  SEL_BUSY2,  32'h1);
      sampleNow();

      // Independent write of 10 and reserve of 11 on one edge.
      @(negedge clk);
      applyStimulus(1'b1, 5'd10, 32'h00000077, 1'b1, 5'd11, 5'd10, 5'd11);
      @(negedge clk);
      idle(5'd10, 5'd11);
      checkOutput("ind10_rdata1", SEL_RDATA1, 32'h00000077);
      checkOutput("ind10_busy1",  SEL_BUSY1,  32'h0);
      checkOutput("ind11_busy2",  SEL_BUSY2,  32'h1);
      checkOutput("ind11_rdata2", SEL_RDATA2, 32'h0);
      sampleNow();

      // Read-during-write of entry 4.
      @(negedge clk);
      applyStimulus(1'b1, 5'd4, 32'h00000011, 1'b0, 5'd0, 5'd4, 5'd7);
      @(negedge clk);
      applyStimulus(1'b1, 5'd4, 32'h00000055, 1'b0, 5'd0, 5'd4, 5'd7);
`ifdef REGFILE_BYPASS_EN
      checkOutput("rdw4_same_rdata1", SEL_RDATA1, 32'h00000055);
`else
      checkOutput("rdw4_same_rdata1", SEL_RDATA1, 32'h00000011);
`endif
      checkOutput("rdw4_same_busy1", SEL_BUSY1,  32'h0);
      checkOutput("rdw4_other",      SEL_RDATA2, 32'h00001234);
      sampleNow();
      @(negedge clk);
      idle(5'd4, 5'd5);
      checkOutput("rdw4_rdata1",  SEL_RDATA1, 32'h00000055);
      checkOutput("untouched5",   SEL_RDATA2, 32'h0);
      sampleNow();

      @(negedge clk);
      if (sbQ.size() != 0) begin
         failCount++;
         $display("[TB] FAIL sb_drain: actual=%0d required=0", sbQ.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end
endmodule
